// File: rtl/xiyiji_panel.sv
// xiyiji_panel: front-panel input receiver for the washer controller.
//
// Synchronises and debounces the raw select/start/emergency button levels, turns accepted select
// presses into a wrapping wash-mode code and hands the xiyiji sequencer one-cycle start/select
// pulses plus a latched emergency-stop flag.
//
// Ports:
//   clk          system clock, everything on the rising edge
//   rst          synchronous, active-high reset
//   select       raw mode-select button level (asynchronous)
//   start        raw start button level (asynchronous)
//   emergency    raw emergency-stop switch level (asynchronous)
//   busy         sequencer is running a wash cycle
//   mode_c       selected wash mode, 0..NUM_MODES-1
//   sel_pulse    one-cycle pulse per accepted select press
//   start_pulse  one-cycle run request
//   estop        latched emergency stop
//
// Build option:
//   XIYIJI_PANEL_LONGPRESS_EN  when defined, holding select for LONG_CYCLES clocks clears mode_c
//                              (once per press). Undefined: no hold counter, LONG_CYCLES absent.

module xiyiji_panel #(
  parameter int unsigned DEB_CYCLES  = 4,
  parameter int unsigned NUM_MODES   = 3
`ifdef XIYIJI_PANEL_LONGPRESS_EN
  ,
  parameter int unsigned LONG_CYCLES = 20
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       select,
  input  logic       start,
  input  logic       emergency,
  input  logic       busy,
  output logic [1:0] mode_c,
  output logic       sel_pulse,
  output logic       start_pulse,
  output logic       estop
);

  // Input lanes: bit 0 select, bit 1 start, bit 2 emergency.
  localparam int unsigned CntW    = $clog2(DEB_CYCLES + 1);
  localparam logic [CntW-1:0] DebMax = CntW'(DEB_CYCLES);
  localparam logic [1:0] ModeMax  = 2'(NUM_MODES - 1);

  logic [2:0]           raw;
  logic [2:0]           sync1_q, sync2_q;
  logic [2:0]           deb_q, deb_d;
  logic [2:0]           prev_q;
  logic [2:0][CntW-1:0] cnt_q, cnt_d;
  logic [2:0]           rise;

  logic [1:0] mode_q, mode_d;
  logic       sel_q, sel_d;
  logic       start_q, start_d;
  logic       estop_q, estop_d;

  assign raw  = {emergency, start, select};
  assign rise = deb_q & ~prev_q;

  // Debounce: count clocks the synchronised level disagrees with the debounced one; the flip
  // happens on the clock after the count has reached DEB_CYCLES.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DebMax) begin
          deb_d[i] = ~deb_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

`ifdef XIYIJI_PANEL_LONGPRESS_EN
  localparam int unsigned LongW = $clog2(LONG_CYCLES + 1);
  localparam logic [LongW-1:0] LongMax = LongW'(LONG_CYCLES);

  logic [LongW-1:0] long_cnt_q, long_cnt_d;
  logic             long_done_q, long_done_d;
  logic             long_ok, long_fire, long_clear;

  // Count only clocks after the rise cycle so the clear lands LONG_CYCLES+1 after the increment.
  assign long_ok   = deb_q[0] & prev_q[0] & ~busy & ~estop_q;
  assign long_fire = long_ok & (long_cnt_q == LongMax) & ~long_done_q;

  always_comb begin
    long_cnt_d = '0;
    if (long_ok) begin
      long_cnt_d = (long_cnt_q == LongMax) ? long_cnt_q : long_cnt_q + LongW'(1);
    end
    // Remember the clear until select is released so it fires once per press.
    long_done_d = deb_q[0] & (long_done_q | long_clear);
  end
`endif

  // Event priority: emergency > start > select (> long-press clear).
  always_comb begin
    mode_d  = mode_q;
    sel_d   = 1'b0;
    start_d = 1'b0;
    estop_d = estop_q;
`ifdef XIYIJI_PANEL_LONGPRESS_EN
    long_clear = 1'b0;
`endif
    if (rise[2]) begin
      estop_d = 1'b1;
    end else if (rise[1]) begin
      if (estop_q) begin
        // A start edge is the acknowledge that clears a stop, but only once the switch is released.
        if (!deb_q[2]) begin
          estop_d = 1'b0;
        end
      end else if (!busy) begin
        start_d = 1'b1;
      end
    end else if (rise[0]) begin
      if (!busy && !estop_q) begin
        sel_d  = 1'b1;
        mode_d = (mode_q == ModeMax) ? 2'd0 : mode_q + 2'd1;
      end
    end
`ifdef XIYIJI_PANEL_LONGPRESS_EN
    else if (long_fire) begin
      mode_d     = 2'd0;
      long_clear = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      prev_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= '0;
      sel_q   <= 1'b0;
      start_q <= 1'b0;
      estop_q <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      prev_q  <= deb_q;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      sel_q   <= sel_d;
      start_q <= start_d;
      estop_q <= estop_d;
    end
  end

`ifdef XIYIJI_PANEL_LONGPRESS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      long_cnt_q  <= '0;
      long_done_q <= 1'b0;
    end else begin
      long_cnt_q  <= long_cnt_d;
      long_done_q <= long_done_d;
    end
  end
`endif

  assign mode_c      = mode_q;
  assign sel_pulse   = sel_q;
  assign start_pulse = start_q;
  assign estop       = estop_q;

endmodule
